riscv32ima_dmem_arb: RTL and testbench
======================================

# riscv32ima_dmem_arb

Two-port arbiter that shares the single 64-bit data-memory port (`d_*`) between the load/store unit (port 0) and a secondary requester (port 1, e.g. debug or DMA). It selects one request per cycle with round-robin or fixed priority. It locks the grant while memory stalls, and steers the one-cycle-later read response back to the winning port. It sits between the LSU and the memory macro, and on each side presents the same active-low chip-select/write-enable protocol the memory uses.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 64, memory word width
- `FIXED_PRIO`, 0, 0 = round-robin; 1 = port 0 always wins when requesting
- `clk`  in  1  single clock, rising edge
- `nrst`  in  1  reset, asynchronous, active-low
- `p0_ncs`, `p1_ncs`  in  1  request, active-low
- `p0_nwe`, `p1_nwe`  in  1  0 = write, 1 = read
- `p0_addr`, `p1_addr`  in  ADDR_WIDTH  address, passed through unmodified
- `p0_wdata`, `p1_wdata`  in  DATA_WIDTH  write data
- `p0_wmask`, `p1_wmask`  in  DATA_WIDTH  bit mask, 0 = write this bit
- `p0_stall`, `p1_stall`  out  1  request not accepted this cycle; requester holds request stable
- `p0_rvalid`, `p1_rvalid`  out  1  read data valid for this port this cycle
- `p0_rdata`, `p1_rdata`  out  DATA_WIDTH  both driven directly from `d_rdata`
- `d_ncs`  out  1  memory select, active-low
- `d_nwe`  out  1  memory write enable, active-low
- `d_addr`  out  ADDR_WIDTH  memory address
- `d_wdata`  out  DATA_WIDTH  memory write data
- `d_wmask`  out  DATA_WIDTH  memory write mask
- `d_rdata`  in  DATA_WIDTH  memory read data, valid the cycle after acceptance
- `d_stall`  in  1  memory busy; request presented this cycle is not accepted

## Operation
- **Request.** A port requests when `pN_ncs` = 0. A request is **accepted** in a cycle with `d_ncs` = 0 and `d_stall` = 0.
- **State machine:** IDLE, LOCK0, LOCK1.
  - **IDLE:** grant is computed combinationally from the current requests.
    - Round-robin: if both ports request, the port opposite to register `last` wins; otherwise the single requester wins.
    - FIXED_PRIO = 1: port 0 wins whenever it requests.
  - **IDLE transitions:**
    - Grant issued and `d_stall` = 1 → LOCKn (n = granted port).
    - Grant accepted → stay in IDLE and set `last` = n.
  - **LOCKn:** grant is held on port n regardless of the other port's request.
    - Accepted (`d_stall` = 0) → IDLE, `last` = n.
    - Port n withdraws its request (protocol violation) → IDLE without acceptance; `d_ncs` = 1 that cycle.
- **Memory-side mux.** `d_ncs` = 0 iff a grant exists. `d_nwe`, `d_addr`, `d_wdata`, `d_wmask` are taken from the granted port. With no grant they are `d_nwe` = 1, `d_addr` = 0, `d_wdata` = 0, `d_wmask` = all-ones.
- **Stall.** `pN_stall` = requesting AND (not granted OR `d_stall`). A non-requesting port sees `pN_stall` = 0.
- **Read response.** On acceptance of a read by port n, register `rsp_vld` = 1 and `rsp_port` = n. The following cycle `pn_rvalid` = 1 and the other port's `rvalid` = 0. Writes produce no `rvalid`.
- **Back-to-back reads.** Supported; at most one response is in flight per cycle.

## Timing
- Arbitration latency: 0 cycles; grant and `d_*` are combinational from the requests and state.
- Read latency: `rvalid` is asserted exactly 1 cycle after the accept edge.
- Throughput: 1 accepted transfer per cycle while `d_stall` = 0.
  - Round-robin with both ports requesting continuously: accepts alternate p0, p1, p0, ….
- **Reset (`nrst` = 0, asynchronous):**
  - State = IDLE, `last` = 1 (so port 0 wins the first contested cycle), `rsp_vld` = 0.
  - Outputs forced: `d_ncs` = 1, `d_nwe` = 1, `p0_rvalid` = `p1_rvalid` = 0, `pN_stall` = ~`pN_ncs`.
- **Reset mid-operation:** an in-flight read response is dropped; no `rvalid` is asserted after `nrst` deasserts.
- **Simultaneous events:**
  - A new request arriving on the non-locked port during LOCKn is ignored until LOCKn exits.
  - A request on the just-served port in the accept cycle competes normally next cycle, with `last` already updated.

## Test plan
- **Reset priority.** `nrst` = 0 with `p0_ncs` = 0 → `d_ncs` = 1, `p0_stall` = 1. Release reset, both ports requesting → first cycle `d_addr` = `p0_addr`, `p1_stall` = 1.
- **Single read.** p0 reads 0x100 with `d_stall` = 0 → `d_ncs` = 0, `d_nwe` = 1, `d_addr` = 0x100. Next cycle with `d_rdata` = 0x1122334455667788 → `p0_rvalid` = 1, `p0_rdata` = 0x1122334455667788, `p1_rvalid` = 0.
- **Round-robin writes.** Both ports write continuously for 4 cycles, p0 to 0x8 and p1 to 0x10 → `d_addr` sequence 0x8, 0x10, 0x8, 0x10, with `p0_stall`/`p1_stall` complementary each cycle.
- **Lock under stall.** p1 granted and `d_stall` = 1 for 3 cycles while p0 also requests → `d_addr` = `p1_addr` all 3 cycles, both stalls = 1. Cycle 4, `d_stall` = 0 → p1 accepted. Cycle 5 → p0 granted.
- **Fixed priority.** FIXED_PRIO = 1, both ports request for 3 cycles → p0 accepted every cycle and `p1_stall` = 1 throughout.
- **Reset mid-read.** p0 read accepted, then `nrst` pulsed low for half a cycle before the next edge → `p0_rvalid` stays 0, and the state returns to IDLE.

Source files
------------

// File: rtl/riscv32ima_dmem_arb.sv
// Two-port data-memory arbiter: LSU (p0) and secondary master (p1) share one
// 64-bit d_* port; round-robin or fixed priority, grant locked while d_stall.
module riscv32ima_dmem_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  p0_ncs,
  input  logic                  p0_nwe,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [DATA_WIDTH-1:0] p0_wmask,
  output logic                  p0_stall,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_ncs,
  input  logic                  p1_nwe,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic [DATA_WIDTH-1:0] p1_wmask,
  output logic                  p1_stall,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  d_ncs,
  output logic                  d_nwe,
  output logic [ADDR_WIDTH-1:0] d_addr,
  output logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_wmask,
  input  logic [DATA_WIDTH-1:0] d_rdata,
  input  logic                  d_stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   rsp_vld_q, rsp_vld_d;
  logic   rsp_port_q, rsp_port_d;

  logic req0, req1;
  logic gnt0, gnt1, gnt_any, acc;

  assign req0 = ~p0_ncs;
  assign req1 = ~p1_ncs;

  // Grant is suppressed in reset so d_ncs stays high and
  // both requesters see stall = request.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (nrst) begin
      unique case (state_q)
        LOCK0: gnt0 = req0;
        LOCK1: gnt1 = req1;
        default: begin
          if (FIXED_PRIO) begin
            gnt0 = req0;
            gnt1 = req1 & ~req0;
          end else begin
            gnt0 = req0 & (~req1 | last_q);
            gnt1 = req1 & (~req0 | ~last_q);
          end
        end
      endcase
    end
  end

  assign gnt_any = gnt0 | gnt1;
  assign acc     = gnt_any & ~d_stall;

  always_comb begin
    d_ncs   = 1'b1;
    d_nwe   = 1'b1;
    d_addr  = '0;
    d_wdata = '0;
    d_wmask = '1;
    unique case (1'b1)
      gnt0: begin
        d_ncs   = 1'b0;
        d_nwe   = p0_nwe;
        d_addr  = p0_addr;
        d_wdata = p0_wdata;
        d_wmask = p0_wmask;
      end
      gnt1: begin
        d_ncs   = 1'b0;
        d_nwe   = p1_nwe;
        d_addr  = p1_addr;
        d_wdata = p1_wdata;
        d_wmask = p1_wmask;
      end
      default: ;
    endcase
  end

  assign p0_stall = req0 & (~gnt0 | d_stall);
  assign p1_stall = req1 & (~gnt1 | d_stall);

  // A stalled grant locks; losing the request while
  // locked drops back to IDLE with nothing accepted.
  always_comb begin
    state_d    = IDLE;
    last_d     = last_q;
    rsp_vld_d  = acc & d_nwe;
    rsp_port_d = rsp_port_q;
    if (acc) begin
      last_d     = gnt1;
      rsp_port_d = gnt1;
    end else if (gnt_any) begin
      state_d = gnt1 ? LOCK1 : LOCK0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      rsp_vld_q  <= 1'b0;
      rsp_port_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_port_q <= rsp_port_d;
    end
  end

  assign p0_rvalid = rsp_vld_q & ~rsp_port_q;
  assign p1_rvalid = rsp_vld_q & rsp_port_q;
  assign p0_rdata  = d_rdata;
  assign p1_rdata  = d_rdata;

endmodule

// File: tb/tb_riscv32ima_dmem_arb.sv
// Bench for riscv32ima_dmem_arb: vector table, hand sequences and a
// randomized run against a transaction-level model (RR and fixed prio).
module tb_riscv32ima_dmem_arb;

  logic        clk;
  logic        nrst;
  logic        p0_ncs, p0_nwe, p1_ncs, p1_nwe;
  logic [31:0] p0_addr, p1_addr;
  logic [63:0] p0_wdata, p1_wdata, p0_wmask, p1_wmask;
  logic [63:0] d_rdata;
  logic        d_stall;

  logic [1:0]  d_ncs_o, d_nwe_o;
  logic [1:0]  s0_o, s1_o, rv0_o, rv1_o;
  logic [31:0] d_addr_o [2];
  logic [63:0] d_wdata_o [2];
  logic [63:0] d_wmask_o [2];
  logic [63:0] rd0_o [2];
  logic [63:0] rd1_o [2];

  int n_cmp;
  int n_bad;

  riscv32ima_dmem_arb #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .nrst(nrst),
    .p0_ncs(p0_ncs), .p0_nwe(p0_nwe), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_stall(s0_o[0]), .p0_rvalid(rv0_o[0]), .p0_rdata(rd0_o[0]),
    .p1_ncs(p1_ncs), .p1_nwe(p1_nwe), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_stall(s1_o[0]), .p1_rvalid(rv1_o[0]), .p1_rdata(rd1_o[0]),
    .d_ncs(d_ncs_o[0]), .d_nwe(d_nwe_o[0]), .d_addr(d_addr_o[0]),
    .d_wdata(d_wdata_o[0]), .d_wmask(d_wmask_o[0]),
    .d_rdata(d_rdata), .d_stall(d_stall)
  );

  riscv32ima_dmem_arb #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .nrst(nrst),
    .p0_ncs(p0_ncs), .p0_nwe(p0_nwe), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_stall(s0_o[1]), .p0_rvalid(rv0_o[1]), .p0_rdata(rd0_o[1]),
    .p1_ncs(p1_ncs), .p1_nwe(p1_nwe), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_stall(s1_o[1]), .p1_rvalid(rv1_o[1]), .p1_rdata(rd1_o[1]),
    .d_ncs(d_ncs_o[1]), .d_nwe(d_nwe_o[1]), .d_addr(d_addr_o[1]),
    .d_wdata(d_wdata_o[1]), .d_wmask(d_wmask_o[1]),
    .d_rdata(d_rdata), .d_stall(d_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #2;
    nrst = 1'b1;
  endtask

  // Transaction-level reference: who owns the port, who was served last,
  // and which port (if any) gets read data next cycle.
  int m_last [2];
  int m_lock [2];
  int m_rv   [2];
  int m_rp   [2];

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 1;
      m_lock[k] = -1;
      m_rv[k]   = 0;
      m_rp[k]   = 0;
    end
  endfunction

  function automatic int m_win(int k, bit r0, bit r1);
    if (m_lock[k] == 0) return r0 ? 0 : -1;
    if (m_lock[k] == 1) return r1 ? 1 : -1;
    if (r0 && r1) return (k == 1) ? 0 : 1 - m_last[k];
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic void m_edge(int k, int g, bit stall, bit rd);
    m_rv[k] = 0;
    if (g < 0) begin
      m_lock[k] = -1;
    end else if (stall) begin
      m_lock[k] = g;
    end else begin
      m_lock[k] = -1;
      m_last[k] = g;
      m_rv[k]   = rd ? 1 : 0;
      m_rp[k]   = g;
    end
  endfunction

  typedef struct {
    logic        ncs0, nwe0, ncs1, nwe1, dst;
    logic [31:0] a0, a1;
    logic        dncs, dnwe;
    logic [31:0] daddr;
    logic        s0, s1, rv0, rv1;
  } vec_t;

  vec_t tbl [14];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tbl[0]  = '{0,0,0,0,0,32'h8,  32'h10,0,0,32'h8,  0,1,0,0};
    tbl[1]  = '{0,0,0,0,0,32'h8,  32'h10,0,0,32'h10, 1,0,0,0};
    tbl[2]  = '{0,0,0,0,0,32'h8,  32'h10,0,0,32'h8,  0,1,0,0};
    tbl[3]  = '{0,0,0,0,0,32'h8,  32'h10,0,0,32'h10, 1,0,0,0};
    tbl[4]  = '{1,1,0,1,1,32'h0,  32'h20,0,1,32'h20, 0,1,0,0};
    tbl[5]  = '{0,0,0,1,1,32'h8,  32'h20,0,1,32'h20, 1,1,0,0};
    tbl[6]  = '{0,0,0,1,1,32'h8,  32'h20,0,1,32'h20, 1,1,0,0};
    tbl[7]  = '{0,0,0,1,0,32'h8,  32'h20,0,1,32'h20, 1,0,0,0};
    tbl[8]  = '{0,1,0,1,0,32'h100,32'h20,0,1,32'h100,0,1,0,1};
    tbl[9]  = '{1,1,1,1,0,32'h0,  32'h0, 1,1,32'h0,  0,0,1,0};
    tbl[10] = '{1,1,1,1,0,32'h0,  32'h0, 1,1,32'h0,  0,0,0,0};
    tbl[11] = '{0,1,1,1,1,32'h40, 32'h0, 0,1,32'h40, 1,0,0,0};
    tbl[12] = '{1,1,0,0,0,32'h0,  32'h50,1,1,32'h0,  0,1,0,0};
    tbl[13] = '{1,1,0,0,0,32'h0,  32'h50,0,0,32'h50, 0,0,0,0};

    p0_ncs = 1'b0; p0_nwe = 1'b0; p0_addr = 32'h8;
    p1_ncs = 1'b1; p1_nwe = 1'b0; p1_addr = 32'h10;
    p0_wdata = 64'hA0A0; p1_wdata = 64'hB1B1;
    p0_wmask = 64'h0;    p1_wmask = 64'hFF;
    d_rdata = 64'h1122334455667788;
    d_stall = 1'b0;
    nrst = 1'b0;

    // reset priority
    #2;
    chk("rst d_ncs", {63'd0, d_ncs_o[0]}, 64'd1);
    chk("rst d_nwe", {63'd0, d_nwe_o[0]}, 64'd1);
    chk("rst p0_stall", {63'd0, s0_o[0]}, 64'd1);
    chk("rst p1_stall", {63'd0, s1_o[0]}, 64'd0);
    chk("rst rvalid", {62'd0, rv1_o[0], rv0_o[0]}, 64'd0);
    p1_ncs = 1'b0;
    #1;
    chk("rst p1_stall req", {63'd0, s1_o[0]}, 64'd1);
    step();
    nrst = 1'b1;
    #2;
    chk("post-rst d_addr", {32'd0, d_addr_o[0]}, 64'h8);
    chk("post-rst p1_stall", {63'd0, s1_o[0]}, 64'd1);
    chk("post-rst p0_stall", {63'd0, s0_o[0]}, 64'd0);
    step();

    // vector table on the round-robin instance
    do_reset();
    for (int i = 0; i < 14; i++) begin
      p0_ncs = tbl[i].ncs0; p0_nwe = tbl[i].nwe0; p0_addr = tbl[i].a0;
      p1_ncs = tbl[i].ncs1; p1_nwe = tbl[i].nwe1; p1_addr = tbl[i].a1;
      d_stall = tbl[i].dst;
      #2;
      chk($sformatf("v%0d d_ncs", i), {63'd0, d_ncs_o[0]}, {63'd0, tbl[i].dncs});
      chk($sformatf("v%0d d_nwe", i), {63'd0, d_nwe_o[0]}, {63'd0, tbl[i].dnwe});
      chk($sformatf("v%0d d_addr", i), {32'd0, d_addr_o[0]}, {32'd0, tbl[i].daddr});
      chk($sformatf("v%0d p0_stall", i), {63'd0, s0_o[0]}, {63'd0, tbl[i].s0});
      chk($sformatf("v%0d p1_stall", i), {63'd0, s1_o[0]}, {63'd0, tbl[i].s1});
      chk($sformatf("v%0d p0_rvalid", i), {63'd0, rv0_o[0]}, {63'd0, tbl[i].rv0});
      chk($sformatf("v%0d p1_rvalid", i), {63'd0, rv1_o[0]}, {63'd0, tbl[i].rv1});
      if (tbl[i].rv0)
        chk($sformatf("v%0d p0_rdata", i), rd0_o[0], 64'h1122334455667788);
      step();
    end

    // fixed priority: p0 wins every contested cycle
    do_reset();
    p0_ncs = 1'b0; p0_nwe = 1'b0; p0_addr = 32'h8;
    p1_ncs = 1'b0; p1_nwe = 1'b0; p1_addr = 32'h10;
    d_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("fp%0d d_ncs", i), {63'd0, d_ncs_o[1]}, 64'd0);
      chk($sformatf("fp%0d d_addr", i), {32'd0, d_addr_o[1]}, 64'h8);
      chk($sformatf("fp%0d p0_stall", i), {63'd0, s0_o[1]}, 64'd0);
      chk($sformatf("fp%0d p1_stall", i), {63'd0, s1_o[1]}, 64'd1);
      step();
    end

    // reset while a read response is pending
    do_reset();
    p0_ncs = 1'b0; p0_nwe = 1'b1; p0_addr = 32'h100;
    p1_ncs = 1'b1;
    #2;
    chk("mid accept d_ncs", {63'd0, d_ncs_o[0]}, 64'd0);
    step();
    p0_ncs = 1'b1;
    #1;
    nrst = 1'b0;
    #1;
    chk("mid rst p0_rvalid", {63'd0, rv0_o[0]}, 64'd0);
    #4;
    nrst = 1'b1;
    #1;
    chk("mid rel p0_rvalid", {63'd0, rv0_o[0]}, 64'd0);
    step();
    chk("mid next p0_rvalid", {63'd0, rv0_o[0]}, 64'd0);
    p0_ncs = 1'b0; p0_nwe = 1'b0; p0_addr = 32'h8;
    p1_ncs = 1'b0; p1_nwe = 1'b0; p1_addr = 32'h10;
    #2;
    chk("mid idle d_addr", {32'd0, d_addr_o[0]}, 64'h8);
    chk("mid idle p1_stall", {63'd0, s1_o[0]}, 64'd1);
    step();

    // randomized run against the reference model
    do_reset();
    m_reset();
    for (int c = 0; c < 600; c++) begin
      p0_ncs   = ($urandom_range(0, 3) == 0);
      p1_ncs   = ($urandom_range(0, 3) == 0);
      p0_nwe   = $urandom_range(0, 1);
      p1_nwe   = $urandom_range(0, 1);
      p0_addr  = $urandom;
      p1_addr  = $urandom;
      p0_wdata = {$urandom, $urandom};
      p1_wdata = {$urandom, $urandom};
      p0_wmask = {$urandom, $urandom};
      p1_wmask = {$urandom, $urandom};
      d_rdata  = {$urandom, $urandom};
      d_stall  = ($urandom_range(0, 9) < 3);
      #2;
      for (int k = 0; k < 2; k++) begin
        int   g;
        logic e_nwe;
        logic [31:0] e_addr;
        logic [63:0] e_wd, e_wm;
        g = m_win(k, !p0_ncs, !p1_ncs);
        e_nwe  = 1'b1;
        e_addr = '0;
        e_wd   = '0;
        e_wm   = '1;
        if (g == 0) begin
          e_nwe = p0_nwe; e_addr = p0_addr; e_wd = p0_wdata; e_wm = p0_wmask;
        end else if (g == 1) begin
          e_nwe = p1_nwe; e_addr = p1_addr; e_wd = p1_wdata; e_wm = p1_wmask;
        end
        chk($sformatf("r%0d.%0d d_ncs", c, k), {63'd0, d_ncs_o[k]},
            {63'd0, g < 0});
        chk($sformatf("r%0d.%0d d_nwe", c, k), {63'd0, d_nwe_o[k]},
            {63'd0, e_nwe});
        chk($sformatf("r%0d.%0d d_addr", c, k), {32'd0, d_addr_o[k]},
            {32'd0, e_addr});
        chk($sformatf("r%0d.%0d d_wdata", c, k), d_wdata_o[k], e_wd);
        chk($sformatf("r%0d.%0d d_wmask", c, k), d_wmask_o[k], e_wm);
        chk($sformatf("r%0d.%0d p0_stall", c, k), {63'd0, s0_o[k]},
            {63'd0, !p0_ncs && (g != 0 || d_stall)});
        chk($sformatf("r%0d.%0d p1_stall", c, k), {63'd0, s1_o[k]},
            {63'd0, !p1_ncs && (g != 1 || d_stall)});
        chk($sformatf("r%0d.%0d p0_rvalid", c, k), {63'd0, rv0_o[k]},
            {63'd0, m_rv[k] == 1 && m_rp[k] == 0});
        chk($sformatf("r%0d.%0d p1_rvalid", c, k), {63'd0, rv1_o[k]},
            {63'd0, m_rv[k] == 1 && m_rp[k] == 1});
        chk($sformatf("r%0d.%0d p0_rdata", c, k), rd0_o[k], d_rdata);
        chk($sformatf("r%0d.%0d p1_rdata", c, k), rd1_o[k], d_rdata);
        m_edge(k, g, d_stall, e_nwe);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
